mem_stage: RTL and testbench

Memory-access pipeline stage that sits directly downstream of EX and upstream of WB. It registers the EX/MEM bus under the shared stall vector and selects between the ALU result and aligned, extended load data from the synchronous data SRAM. It drives the MEM/WB bus and a combinational forwarding bus back to ID. The read-data hold register keeps load data stable while the stage is stalled and the SRAM output moves on.

---
 rtl/mem_stage_pkg.sv | 43 ++++
 rtl/mem_stage_if.sv | 28 ++
 rtl/mem_stage_load_ext.sv | 39 +++
 rtl/mem_stage.sv | 71 +++++++
 tb/tb_mem_stage.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, EX/MEM and MEM/WB bundles and load op codes
// for the memory-access stage.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_RF_WD = 38;
  localparam int StallBus     = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [2:0] MEM_LW  = 3'b000;
  localparam logic [2:0] MEM_LB  = 3'b001;
  localparam logic [2:0] MEM_LBU = 3'b010;
  localparam logic [2:0] MEM_LH  = 3'b011;
  localparam logic [2:0] MEM_LHU = 3'b100;

  typedef struct packed {
    logic [2:0]  mem_op;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_wb_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_rf_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM input bus, SRAM read data, stall vector and the
// MEM/WB plus forwarding outputs of the memory stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [StallBus-1:0]     stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;

  modport master (
    output stall,
    output ex_to_mem_bus,
    output data_sram_rdata,
    input  mem_to_wb_bus,
    input  mem_to_rf_bus
  );

  modport slave (
    input  stall,
    input  ex_to_mem_bus,
    input  data_sram_rdata,
    output mem_to_wb_bus,
    output mem_to_rf_bus
  );

endinterface

// File: rtl/mem_stage_load_ext.sv
// Byte/halfword lane select and sign/zero extension of
// raw SRAM read data.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  a,
  input  logic [31:0] raw,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    unique case (a)
      2'd0: byte_lane = raw[7:0];
      2'd1: byte_lane = raw[15:8];
      2'd2: byte_lane = raw[23:16];
      2'd3: byte_lane = raw[31:24];
    endcase
  end

  // halfword alignment is guaranteed upstream, so a[0] is not checked
  assign half_lane = a[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    load_data = raw;
    unique case (mem_op)
      MEM_LB:  load_data = {{24{byte_lane[7]}}, byte_lane};
      MEM_LBU: load_data = {24'h0, byte_lane};
      MEM_LH:  load_data = {{16{half_lane[15]}}, half_lane};
      MEM_LHU: load_data = {16'h0, half_lane};
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, load-data hold,
// load extension and writeback select.
module mem_stage
  import mem_stage_pkg::*;
(
  input logic     clk,
  input logic     rst,
  mem_stage_if.slave bus
);

  ex_mem_t     ex_r;
  logic [31:0] hold_data;
  logic        hold_valid;
  logic        held;
  logic [31:0] raw;
  logic [31:0] load_data;
  logic        is_load;
  mem_wb_t     wb;
  mem_rf_t     rf;
  logic        unused_stall;

  assign unused_stall = ^{bus.stall[5], bus.stall[2:0]};

  assign held = (bus.stall[3] == STOP) && (bus.stall[4] == STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r <= '0;
    end else if (bus.stall[3] == NO_STOP) begin
      ex_r <= ex_mem_t'(bus.ex_to_mem_bus);
    end else if (bus.stall[4] == NO_STOP) begin
      ex_r <= '0;
    end
  end

  // SRAM data is valid one cycle only; capture it on the first held cycle
  always_ff @(posedge clk) begin
    if (rst || !held) begin
      hold_valid <= 1'b0;
    end else if (!hold_valid) begin
      hold_data  <= bus.data_sram_rdata;
      hold_valid <= 1'b1;
    end
  end

  assign raw = hold_valid ? hold_data : bus.data_sram_rdata;

  load_ext u_load_ext (
    .mem_op    (ex_r.mem_op),
    .a         (ex_r.ex_result[1:0]),
    .raw       (raw),
    .load_data (load_data)
  );

  assign is_load = ex_r.sel_rf_res & ex_r.data_ram_en
                 & ~|ex_r.data_ram_wen;

  always_comb begin
    wb.pc       = ex_r.pc;
    wb.rf_we    = ex_r.rf_we;
    wb.rf_waddr = ex_r.rf_waddr;
    wb.rf_wdata = is_load ? load_data : ex_r.ex_result;
    rf.rf_we    = wb.rf_we;
    rf.rf_waddr = wb.rf_waddr;
    rf.rf_wdata = wb.rf_wdata;
  end

  assign bus.mem_to_wb_bus = wb;
  assign bus.mem_to_rf_bus = rf;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus random stimulus for mem_stage against a
// per-instruction behavioural model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if mif ();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  // model: what instruction sits in MEM and its first-cycle SRAM data
  ex_mem_t     occ;
  logic        first_cycle;
  logic [31:0] first_data;
  logic        model_ok = 1'b0;

  logic        cur_rst;
  logic [5:0]  cur_stall;
  logic [31:0] cur_rdata;
  ex_mem_t     cur_bus;

  task automatic check(input string tag,
                       input logic [69:0] got,
                       input logic [69:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [2:0] op,
                                          input logic [31:0] addr,
                                          input logic [31:0] raw);
    int unsigned sh;
    int unsigned b;
    int unsigned h;
    int          s;
    sh = (addr % 4) * 8;
    b  = (raw >> sh) % 256;
    h  = (raw >> (((addr % 4) / 2) * 16)) % 65536;
    case (op)
      3'd1: begin s = (b >= 128) ? int'(b) - 256 : int'(b);
            return 32'(s); end
      3'd2: return 32'(b);
      3'd3: begin s = (h >= 32768) ? int'(h) - 65536 : int'(h);
            return 32'(s); end
      3'd4: return 32'(h);
      default: return raw;
    endcase
  endfunction

  function automatic logic [69:0] ref_wb(input ex_mem_t e,
                                         input logic [31:0] raw);
    logic [31:0] d;
    bit ld;
    ld = e.sel_rf_res && e.data_ram_en && (e.data_ram_wen == 4'h0);
    d  = ld ? ref_ext(e.mem_op, e.ex_result, raw) : e.ex_result;
    return {e.pc, e.rf_we, e.rf_waddr, d};
  endfunction

  function automatic ex_mem_t mk(input logic [2:0] op,
                                 input logic [31:0] pc,
                                 input logic en,
                                 input logic [3:0] wen,
                                 input logic sel,
                                 input logic [4:0] wa,
                                 input logic [31:0] res);
    ex_mem_t e;
    e.mem_op       = op;
    e.pc           = pc;
    e.data_ram_en  = en;
    e.data_ram_wen = wen;
    e.sel_rf_res   = sel;
    e.rf_we        = 1'b1;
    e.rf_waddr     = wa;
    e.ex_result    = res;
    return e;
  endfunction

  function automatic ex_mem_t ld(input logic [2:0] op,
                                 input logic [31:0] addr);
    return mk(op, 32'h8000_0000 | addr, 1'b1, 4'h0, 1'b1,
              addr[6:2], addr);
  endfunction

  task automatic cyc(input logic r, input logic [5:0] st,
                     input ex_mem_t b, input logic [31:0] rd);
    logic [69:0] e;
    @(negedge clk);
    rst = r;
    mif.stall = st;
    mif.ex_to_mem_bus = b;
    mif.data_sram_rdata = rd;
    cur_rst = r; cur_stall = st; cur_bus = b; cur_rdata = rd;
    #1;
    if (model_ok) begin
      e = ref_wb(occ, first_cycle ? rd : first_data);
      check("wb_bus", mif.mem_to_wb_bus, e);
      check("rf_bus", 70'(mif.mem_to_rf_bus), 70'(e[37:0]));
    end
  endtask

  task automatic fin();
    @(posedge clk);
    model_ok = 1'b1;
    if (cur_rst) begin
      occ = '0; first_cycle = 1'b1;
    end else if (!cur_stall[3]) begin
      occ = cur_bus; first_cycle = 1'b1;
    end else if (!cur_stall[4]) begin
      occ = '0; first_cycle = 1'b1;
    end else if (first_cycle) begin
      first_data = cur_rdata; first_cycle = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic [5:0] st,
                      input ex_mem_t b, input logic [31:0] rd);
    cyc(r, st, b, rd);
    fin();
  endtask

  function automatic logic [31:0] wdata();
    return mif.mem_to_wb_bus[31:0];
  endfunction

  localparam logic [5:0] RUN  = 6'b000000;
  localparam logic [5:0] HOLD = 6'b011000;
  localparam logic [5:0] BUBL = 6'b001000;

  ex_mem_t alu;
  ex_mem_t rb;

  initial begin
    mif.stall = '0;
    mif.ex_to_mem_bus = '0;
    mif.data_sram_rdata = '0;
    alu = mk(3'd0, 32'h44, 1'b0, 4'h0, 1'b0, 5'd9, 32'h1234);

    step(1'b1, RUN, '0, 32'h0);
    step(1'b1, RUN, '0, 32'h0);
    cyc(1'b0, RUN, ld(MEM_LW, 32'h100), $urandom);
    check("reset_out", mif.mem_to_wb_bus, 70'h0);
    fin();

    cyc(1'b0, RUN, ld(MEM_LB, 32'h103), 32'h8081_7F01);
    check("lw", 70'(wdata()), 70'h8081_7F01);
    check("lw_we", 70'(mif.mem_to_wb_bus[37]), 70'h1);
    fin();
    cyc(1'b0, RUN, ld(MEM_LBU, 32'h103), 32'h8012_3456);
    check("lb3", 70'(wdata()), 70'hFFFF_FF80);
    fin();
    cyc(1'b0, RUN, ld(MEM_LB, 32'h101), 32'h8012_3456);
    check("lbu3", 70'(wdata()), 70'h0000_0080);
    fin();
    cyc(1'b0, RUN, ld(MEM_LH, 32'h102), 32'h1234_7F56);
    check("lb1", 70'(wdata()), 70'h0000_007F);
    fin();
    cyc(1'b0, RUN, ld(MEM_LHU, 32'h102), 32'h8001_1234);
    check("lh2", 70'(wdata()), 70'hFFFF_8001);
    fin();
    cyc(1'b0, RUN, ld(MEM_LH, 32'h100), 32'h8001_1234);
    check("lhu2", 70'(wdata()), 70'h0000_8001);
    fin();
    cyc(1'b0, RUN, ld(MEM_LW, 32'h200), 32'h8001_1234);
    check("lh0", 70'(wdata()), 70'h0000_1234);
    fin();

    cyc(1'b0, HOLD, alu, 32'hCAFE_BABE);
    check("hold0", 70'(wdata()), 70'hCAFE_BABE);
    fin();
    for (int i = 1; i < 3; i++) begin
      cyc(1'b0, HOLD, alu, $urandom);
      check("hold", 70'(wdata()), 70'hCAFE_BABE);
      fin();
    end
    cyc(1'b0, RUN, alu, $urandom);
    check("hold_rel", 70'(wdata()), 70'hCAFE_BABE);
    fin();
    cyc(1'b0, BUBL, ld(MEM_LW, 32'h300), $urandom);
    check("alu", 70'(wdata()), 70'h1234);
    fin();
    cyc(1'b0, RUN, ld(MEM_LW, 32'h300), $urandom);
    check("bubble", mif.mem_to_wb_bus, 70'h0);
    fin();

    cyc(1'b0, HOLD, alu, 32'h1111_2222);
    fin();
    cyc(1'b1, HOLD, alu, $urandom);
    check("pre_rst", 70'(wdata()), 70'h1111_2222);
    fin();
    cyc(1'b0, RUN, ld(MEM_LW, 32'h400), $urandom);
    check("rst_hold", mif.mem_to_wb_bus, 70'h0);
    fin();
    cyc(1'b0, RUN, alu, 32'h5555_AAAA);
    check("post_rst", 70'(wdata()), 70'h5555_AAAA);
    fin();

    for (int i = 0; i < 2000; i++) begin
      logic [5:0] st;
      int unsigned k;
      k = $urandom_range(0, 9);
      st = 6'($urandom);
      st[4:3] = (k < 6) ? 2'b00 : (k < 8) ? 2'b11 :
                (k == 8) ? 2'b01 : 2'b10;
      rb = ex_mem_t'({$urandom, $urandom, $urandom});
      rb.data_ram_wen = ($urandom_range(0, 3) == 0) ?
                        4'($urandom) : 4'h0;
      rb.data_ram_en  = ($urandom_range(0, 4) != 0);
      step(($urandom_range(0, 99) == 0), st, rb, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
